// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch-stage PC logic: the pc_src encodings
// that come down the ID/EXE register and the fixed instruction size.
package pc_fetch_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JREG   = 2'b11;

  localparam int unsigned INSN_SIZE = 4;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer. Works on word addresses (pc[ADDR_W-1:2]),
// because the low two PC bits never take part in indexing or tagging.
// The lookup is combinational from the current array contents, so an update
// to the same index in the same cycle is seen only from the next cycle.
module pc_btb
  import pc_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BTB_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] lookup_word,
  output logic              lookup_hit,
  output logic [ADDR_W-1:0] lookup_target,
  input  logic              upd_en,
  input  logic              upd_taken,
  input  logic [ADDR_W-3:0] upd_word,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

  logic [BTB_DEPTH-1:0] valid_p0;
  logic [TAG_W-1:0]     tag_p0    [BTB_DEPTH];
  logic [ADDR_W-1:0]    target_p0 [BTB_DEPTH];

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_tag_hit;

  assign lookup_idx = lookup_word[IDX_W-1:0];
  assign lookup_tag = lookup_word[ADDR_W-3:IDX_W];
  assign upd_idx    = upd_word[IDX_W-1:0];
  assign upd_tag    = upd_word[ADDR_W-3:IDX_W];

  assign lookup_hit    = valid_p0[lookup_idx] && (tag_p0[lookup_idx] == lookup_tag);
  assign lookup_target = target_p0[lookup_idx];
  assign upd_tag_hit   = valid_p0[upd_idx] && (tag_p0[upd_idx] == upd_tag);

  // Valid bits: set on a resolved taken transfer, cleared when the same
  // branch resolves not-taken; reset empties the whole table at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_p0 <= '0;
    end else if (upd_en) begin
      if (upd_taken) begin
        valid_p0[upd_idx] <= 1'b1;
      end else if (upd_tag_hit) begin
        valid_p0[upd_idx] <= 1'b0;
      end
    end
  end

  // Tag and target storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tag_p0[upd_idx]    <= upd_tag;
      target_p0[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with stall hold, mispredict redirect/flush and
// an optional branch target buffer.
// Build option: define PC_FETCH_BTB_EN to include the BTB (pc_btb). Without
// it, prediction is always pc+4 and every taken transfer redirects via flush.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int unsigned      ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned      BTB_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              exe_valid_i,
  input  logic [1:0]        exe_pc_src_i,
  input  logic [ADDR_W-1:0] exe_pc_i,
  input  logic [ADDR_W-1:0] exe_branch_addr_i,
  input  logic [ADDR_W-1:0] exe_jump_addr_i,
  input  logic [ADDR_W-1:0] exe_jr_addr_i,
  input  logic [ADDR_W-1:0] exe_pred_next_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] pred_next_o,
  output logic              pred_taken_o,
  output logic              flush_o
);

  localparam logic [ADDR_W-1:0] INSN_STEP = ADDR_W'(INSN_SIZE);

  if ((BTB_DEPTH < 2) || ((BTB_DEPTH & (BTB_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_fetch_unit: BTB_DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] resolved_next;
  logic              mispredict;

  assign pc_o       = pc_p0;
  assign pc_plus4_o = pc_p0 + INSN_STEP;

  // Actual successor of the instruction in EXE, from its resolved pc_src.
  always_comb begin
    resolved_next = exe_pc_i + INSN_STEP;
    case (exe_pc_src_i)
      PC_SRC_BRANCH: resolved_next = exe_branch_addr_i;
      PC_SRC_JUMP:   resolved_next = exe_jump_addr_i;
      PC_SRC_JREG:   resolved_next = exe_jr_addr_i;
      default:       resolved_next = exe_pc_i + INSN_STEP;
    endcase
  end

  assign mispredict = exe_valid_i && (resolved_next != exe_pred_next_i);
  assign flush_o    = mispredict && !rst;

`ifdef PC_FETCH_BTB_EN
  logic              btb_hit;
  logic [ADDR_W-1:0] btb_target;

  pc_btb #(
    .ADDR_W    (ADDR_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_word   (pc_p0[ADDR_W-1:2]),
    .lookup_hit    (btb_hit),
    .lookup_target (btb_target),
    .upd_en        (exe_valid_i),
    .upd_taken     (exe_pc_src_i != PC_SRC_SEQ),
    .upd_word      (exe_pc_i[ADDR_W-1:2]),
    .upd_target    (resolved_next)
  );

  assign pred_taken_o = btb_hit;
  assign pred_next_o  = btb_hit ? btb_target : pc_plus4_o;
`else
  assign pred_taken_o = 1'b0;
  assign pred_next_o  = pc_plus4_o;
`endif

  // PC register: redirect beats stall, stall beats the predicted successor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0 <= RESET_PC;
    end else if (mispredict) begin
      pc_p0 <= resolved_next;
    end else if (!stall_i) begin
      pc_p0 <= pred_next_o;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus a randomized run
// checked against a behavioural model of the fetch PC and BTB.
module tb_pc_fetch_unit;

  localparam int unsigned DEPTH = 8;
`ifdef PC_FETCH_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        exe_valid_i;
  logic [1:0]  exe_pc_src_i;
  logic [31:0] exe_pc_i, exe_branch_addr_i, exe_jump_addr_i, exe_jr_addr_i, exe_pred_next_i;
  logic [31:0] pc_o, pc_plus4_o, pred_next_o;
  logic        pred_taken_o, flush_o;
  logic [31:0] w_pc, w_pc_plus4, w_pred_next;
  logic        w_pred_taken, w_flush;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_valid [DEPTH];
  logic [31:0] m_src_pc [DEPTH];
  logic [31:0] m_tgt [DEPTH];

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .BTB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .exe_valid_i(exe_valid_i),
    .exe_pc_src_i(exe_pc_src_i), .exe_pc_i(exe_pc_i),
    .exe_branch_addr_i(exe_branch_addr_i), .exe_jump_addr_i(exe_jump_addr_i),
    .exe_jr_addr_i(exe_jr_addr_i), .exe_pred_next_i(exe_pred_next_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .pred_next_o(pred_next_o),
    .pred_taken_o(pred_taken_o), .flush_o(flush_o)
  );

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .BTB_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(stall_i), .exe_valid_i(exe_valid_i),
    .exe_pc_src_i(exe_pc_src_i), .exe_pc_i(exe_pc_i),
    .exe_branch_addr_i(exe_branch_addr_i), .exe_jump_addr_i(exe_jump_addr_i),
    .exe_jr_addr_i(exe_jr_addr_i), .exe_pred_next_i(exe_pred_next_i),
    .pc_o(w_pc), .pc_plus4_o(w_pc_plus4), .pred_next_o(w_pred_next),
    .pred_taken_o(w_pred_taken), .flush_o(w_flush)
  );

  task automatic set_exe(input logic v, input logic [1:0] src, input logic [31:0] epc,
                         input logic [31:0] br, input logic [31:0] jmp,
                         input logic [31:0] jr, input logic [31:0] pred);
    exe_valid_i = v; exe_pc_src_i = src; exe_pc_i = epc;
    exe_branch_addr_i = br; exe_jump_addr_i = jmp; exe_jr_addr_i = jr; exe_pred_next_i = pred;
  endtask

  task automatic clear_exe();
    set_exe(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Redirect the fetch PC to addr via a jump resolving from an unrelated PC (BTB index 1).
  task automatic redirect_to(input logic [31:0] addr);
    set_exe(1'b1, 2'b10, 32'h84, 32'h0, addr, 32'h0, 32'h0);
    @(negedge clk);
    clear_exe();
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_exe();
    stall_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall_i = 1'b0;
    set_exe(1'b1, 2'b10, 32'h20, 32'h0, 32'h400, 32'h0, 32'h0);
    #1;
    tests_run++;
    if (pc_o !== 32'h0 || pc_plus4_o !== 32'h4 || pred_next_o !== 32'h4 || pred_taken_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: pc=%h plus4=%h pred=%h taken=%b, required 0/4/4/0", pc_o, pc_plus4_o, pred_next_o, pred_taken_o);
    end
    tests_run++;
    if (flush_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flush_forced: flush=%b, required 0", flush_o);
    end
    tests_run++;
    if (w_pc !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_reset: pc=%h plus4=%h, required fffffffc/00000000", w_pc, w_pc_plus4);
    end
    clear_exe();
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (w_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_hold_reset: pc=%h, required fffffffc", w_pc);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (pc_o !== 32'(4 * k) || flush_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL seq_fetch[%0d]: pc=%h flush=%b, required %h/0", k, pc_o, flush_o, 32'(4 * k));
      end
      if (k == 0) begin
        @(negedge clk);
        #1;
        tests_run++;
        if (w_pc !== 32'h0) begin
          tests_failed++;
          $display("FAIL wrap_next: pc=%h, required 00000000", w_pc);
        end
      end else begin
        @(negedge clk);
        #1;
      end
    end
    // Asynchronous reset mid-operation, away from any rising edge.
    tests_run++;
    if (pc_o !== 32'h10) begin
      tests_failed++;
      $display("FAIL pre_async_pc: pc=%h, required 00000010", pc_o);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (pc_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h, required 00000000", pc_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_stall();
    tests_run++;
    if (pc_o !== 32'h10) begin
      tests_failed++;
      $display("FAIL stall_start: pc=%h, required 00000010", pc_o);
    end
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (pc_o !== 32'h10) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: pc=%h, required 00000010", k, pc_o);
      end
    end
    stall_i = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (pc_o !== 32'h14) begin
      tests_failed++;
      $display("FAIL stall_resume: pc=%h, required 00000014", pc_o);
    end
  endtask

  task automatic test_mispredict_stall();
    stall_i = 1'b1;
    set_exe(1'b1, 2'b10, 32'h20, 32'h0, 32'h400, 32'h0, 32'h24);
    #1;
    tests_run++;
    if (flush_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mispredict_flush: flush=%b, required 1", flush_o);
    end
    @(negedge clk);
    clear_exe();
    stall_i = 1'b0;
    #1;
    tests_run++;
    if (pc_o !== 32'h400) begin
      tests_failed++;
      $display("FAIL mispredict_redirect: pc=%h, required 00000400", pc_o);
    end
  endtask

`ifdef PC_FETCH_BTB_EN
  task automatic test_btb_train();
    pulse_reset();
    set_exe(1'b1, 2'b01, 32'h20, 32'h100, 32'h0, 32'h0, 32'h24);
    #1;
    tests_run++;
    if (flush_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL train_flush: flush=%b, required 1", flush_o);
    end
    @(negedge clk);
    clear_exe();
    redirect_to(32'h20);
    tests_run++;
    if (pc_o !== 32'h20 || pred_taken_o !== 1'b1 || pred_next_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL btb_hit: pc=%h taken=%b pred=%h, required 00000020/1/00000100", pc_o, pred_taken_o, pred_next_o);
    end
    set_exe(1'b1, 2'b01, 32'h20, 32'h100, 32'h0, 32'h0, 32'h100);
    #1;
    tests_run++;
    if (flush_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL correct_predict: flush=%b, required 0", flush_o);
    end
    @(negedge clk);
    clear_exe();
    #1;
  endtask

  task automatic test_btb_untrain();
    set_exe(1'b1, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0, 32'h100);
    #1;
    tests_run++;
    if (flush_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL untrain_flush: flush=%b, required 1", flush_o);
    end
    @(negedge clk);
    clear_exe();
    #1;
    tests_run++;
    if (pc_o !== 32'h24) begin
      tests_failed++;
      $display("FAIL untrain_pc: pc=%h, required 00000024", pc_o);
    end
    redirect_to(32'h20);
    tests_run++;
    if (pred_taken_o !== 1'b0 || pred_next_o !== 32'h24) begin
      tests_failed++;
      $display("FAIL untrain_lookup: taken=%b pred=%h, required 0/00000024", pred_taken_o, pred_next_o);
    end
  endtask

  task automatic test_btb_alias();
    set_exe(1'b1, 2'b01, 32'h20, 32'h100, 32'h0, 32'h0, 32'h24);
    @(negedge clk);
    set_exe(1'b1, 2'b01, 32'h40, 32'h200, 32'h0, 32'h0, 32'h44);
    @(negedge clk);
    clear_exe();
    redirect_to(32'h20);
    tests_run++;
    if (pred_taken_o !== 1'b0 || pred_next_o !== 32'h24) begin
      tests_failed++;
      $display("FAIL alias_evicted: taken=%b pred=%h, required 0/00000024", pred_taken_o, pred_next_o);
    end
    redirect_to(32'h40);
    tests_run++;
    if (pred_taken_o !== 1'b1 || pred_next_o !== 32'h200) begin
      tests_failed++;
      $display("FAIL alias_survivor: taken=%b pred=%h, required 1/00000200", pred_taken_o, pred_next_o);
    end
  endtask
`else
  task automatic test_no_btb();
    pulse_reset();
    set_exe(1'b1, 2'b01, 32'h20, 32'h100, 32'h0, 32'h0, 32'h24);
    #1;
    tests_run++;
    if (flush_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL taken_flush: flush=%b, required 1", flush_o);
    end
    @(negedge clk);
    clear_exe();
    redirect_to(32'h20);
    tests_run++;
    if (pc_o !== 32'h20 || pred_taken_o !== 1'b0 || pred_next_o !== 32'h24) begin
      tests_failed++;
      $display("FAIL no_btb_lookup: pc=%h taken=%b pred=%h, required 00000020/0/00000024", pc_o, pred_taken_o, pred_next_o);
    end
  endtask
`endif

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6) return 32'($urandom_range(0, 31) * 4);
    if (r < 8) return 32'hFFFF_FFFC;
    return $urandom;
  endfunction

  task automatic test_random();
    logic [31:0] resolved, pred, nxt;
    int unsigned idx, uidx;
    bit hit, misp;
    pulse_reset();
    m_pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    for (int n = 0; n < 500; n++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      set_exe($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), rand_addr(),
              rand_addr(), rand_addr(), rand_addr(), rand_addr());
      case (exe_pc_src_i)
        2'b00:   resolved = exe_pc_i + 32'd4;
        2'b01:   resolved = exe_branch_addr_i;
        2'b10:   resolved = exe_jump_addr_i;
        default: resolved = exe_jr_addr_i;
      endcase
      if ($urandom_range(0, 1) == 0) exe_pred_next_i = resolved;
      idx  = (m_pc >> 2) % DEPTH;
      hit  = BTB_EN && m_valid[idx] && (m_src_pc[idx][31:2] == m_pc[31:2]);
      pred = hit ? m_tgt[idx] : m_pc + 32'd4;
      misp = exe_valid_i && (resolved != exe_pred_next_i);
      #1;
      tests_run++;
      if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4 || pred_next_o !== pred ||
          pred_taken_o !== hit || flush_o !== misp) begin
        tests_failed++;
        $display("FAIL random[%0d]: pc=%h plus4=%h pred=%h taken=%b flush=%b, required %h/%h/%h/%b/%b",
                 n, pc_o, pc_plus4_o, pred_next_o, pred_taken_o, flush_o,
                 m_pc, m_pc + 32'd4, pred, hit, misp);
      end
      nxt = misp ? resolved : (stall_i ? m_pc : pred);
      if (exe_valid_i) begin
        uidx = (exe_pc_i >> 2) % DEPTH;
        if (exe_pc_src_i != 2'b00) begin
          m_valid[uidx] = 1'b1;
          m_src_pc[uidx] = exe_pc_i;
          m_tgt[uidx] = resolved;
        end else if (m_valid[uidx] && m_src_pc[uidx][31:2] == exe_pc_i[31:2]) begin
          m_valid[uidx] = 1'b0;
        end
      end
      m_pc = nxt;
      @(negedge clk);
    end
    clear_exe();
    stall_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    clear_exe();
    test_reset();
    test_stall();
    test_mispredict_stall();
`ifdef PC_FETCH_BTB_EN
    test_btb_train();
    test_btb_untrain();
    test_btb_alias();
`else
    test_no_btb();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised successor to the fetch-stage PC select mux. It holds the program counter register, chooses the next fetch address each cycle, and adds stall hold, mispredict redirect with flush, and an optional direct-mapped branch target buffer (BTB). It sits in IF, takes resolution information from the ID/EXE register, and drives the instruction memory address and the IF/ID PC fields.

## Interface
- ADDR_W, 32, PC and target width in bits.
- RESET_PC, 0, PC value loaded by reset.
- BTB_DEPTH, 8, number of BTB entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall_i  in  1  hold the PC (load-use hazard).
- exe_valid_i  in  1  ID/EXE holds a real, non-bubble instruction.
- exe_pc_src_i  in  2  00 sequential, 01 branch, 10 jump, 11 jump-register.
- exe_pc_i  in  ADDR_W  PC of the EXE instruction.
- exe_branch_addr_i / exe_jump_addr_i / exe_jr_addr_i  in  ADDR_W each  resolved targets.
- exe_pred_next_i  in  ADDR_W  pred_next_o value carried down with the EXE instruction.
- pc_o  out  ADDR_W  current fetch address.
- pc_plus4_o  out  ADDR_W  pc_o + 4.
- pred_next_o  out  ADDR_W  next PC chosen at fetch; software pipelines it to EXE.
- pred_taken_o  out  1  BTB hit on pc_o.
- flush_o  out  1  mispredict; flush IF/ID and ID/EXE on this edge.

## Operation
- resolved_next: exe_pc_i+4 for 00; otherwise the target selected by exe_pc_src_i.
- mispredict = exe_valid_i && (resolved_next != exe_pred_next_i); flush_o = mispredict.
- Next-PC priority, highest first: rst -> RESET_PC; mispredict -> resolved_next (overrides stall); stall_i -> hold pc_o; otherwise -> pred_next_o.
- pred_next_o: BTB hit -> stored target; else pc_plus4_o.
- All address arithmetic is modulo 2^ADDR_W; 0xFFFFFFFC + 4 = 0x00000000. Low two bits are carried unchanged, never checked.
- BTB: direct-mapped; index = pc[log2(BTB_DEPTH)+1:2]; tag = pc[ADDR_W-1:log2(BTB_DEPTH)+2]. Each entry holds valid, tag and target. Hit = valid && tag match.
- BTB update, only when exe_valid_i is high and evaluated on exe_pc_i:
  - pc_src != 00: write valid=1, the tag and resolved_next.
  - pc_src == 00 with a tag hit: clear valid.
  - Otherwise: no change.
- The update is applied even during a stall.
- A same-cycle lookup and update to the same index returns the old contents (read before write).

## Timing
- Reset values: pc_o=RESET_PC; pc_plus4_o=RESET_PC+4; pred_next_o=RESET_PC+4; pred_taken_o=0; flush_o=0 (forced while rst is high); all BTB valid bits 0.
- rst asserted mid-operation clears the PC and BTB immediately. It is asynchronous and does not wait for a clock edge.
- Lookup is combinational from pc_o: pred_next_o and pred_taken_o are valid in the same cycle.
- flush_o is combinational in the cycle the instruction sits in ID/EXE. pc_o equals resolved_next after that edge, a redirect latency of 1 cycle.
- A new BTB entry is visible to lookups from the cycle after the write edge.

## Configuration
- PC_FETCH_BTB_EN defined: the BTB is built and behaves as described above.
- PC_FETCH_BTB_EN undefined:
  - No BTB storage.
  - pred_taken_o ties to 0 and pred_next_o = pc_plus4_o.
  - Any taken pc_src therefore mispredicts, which reproduces the plain select-mux-plus-flush behaviour with a 1-cycle redirect.
  - BTB_DEPTH is ignored.

## Structure
- Shared package pc_fetch_pkg holds:
  - PC_SRC_SEQ/BRANCH/JUMP/JREG = 2'b00/01/10/11.
  - The default instruction size of 4.
- One sub-module, pc_btb, owns the entry array, the lookup port and the update port. It is instantiated only under PC_FETCH_BTB_EN.
- Next-PC priority logic and the PC register stay in pc_fetch_unit.

## Test plan
- **Reset and sequential fetch.** Assert rst and release it, with no EXE activity. Required: pc_o=0, then 4, 8, 12; flush_o=0 throughout.
- **Stall hold.** Assert stall_i for 3 cycles at pc_o=0x10. Required: pc_o stays 0x10; it resumes at 0x14 on the first edge after stall_i drops.
- **Mispredict during stall.** Apply exe_valid_i=1, pc_src=10, jump_addr=0x400, exe_pred_next=0x24 together with stall_i=1. Required: flush_o=1; pc_o=0x400 after the edge.
- **BTB train and hit (BTB_EN).** First pass: branch at 0x20 taken to 0x100, mispredicted. Required: a flush, then on refetch of 0x20, pred_taken_o=1 and pred_next_o=0x100. When that refetch resolves in EXE with exe_pred_next=0x100: no flush.
- **BTB untrain.** The same 0x20 branch now resolves with pc_src=00 and exe_pred_next=0x100. Required: flush_o=1; pc_o=0x24; the next fetch of 0x20 gives pred_taken_o=0.
- **Alias and wrap.** Entries at 0x20 and 0x40 with BTB_DEPTH=8 share index 0 with different tags: the second write evicts the first. RESET_PC=0xFFFFFFFC: the next pc_o is 0x00000000.
